mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the MIPS datapath. It sequences one instruction at a time through fetch, decode, execute, memory and write-back states, driving the datapath's register-enable and mux-select lines from the latched opcode/funct and the ALU zero flag. It sits beside the `Mips` datapath, replacing the single-cycle combinational controller. It stalls on a memory-ready handshake and counts retired instructions.

## Interface
- `CNT_W`, 32: width of retired-instruction counter.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `opcode`  in  6  instr[31:26] from the instruction register (IR).
- `funct`  in  6  instr[5:0] from IR.
- `zero`  in  1  ALU result == 0.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `mem_req`  out  1  memory access active (fetch, load or store).
- `pc_write`  out  1  PC load enable.
- `pc_src`  out  2  0 ALU result, 1 ALUOut (branch target), 2 {PC[31:28],idx,00}, 3 rs.
- `ir_write`  out  1  IR load enable.
- `iord`  out  1  memory address: 0 PC, 1 ALUOut.
- `mem_write`  out  1  data store enable.
- `reg_write`  out  1  GRF write enable.
- `reg_dst`  out  2  0 rt, 1 rd, 2 $31.
- `mem_to_reg`  out  2  0 ALUOut, 1 MDR, 2 PC.
- `alu_src_a`  out  1  0 PC, 1 rs.
- `alu_src_b`  out  2  0 rt, 1 const 4, 2 ext(imm), 3 ext(imm)<<2.
- `alu_op`  out  2  0 ADD, 1 SUB, 2 OR, 3 LUI.
- `ext_op`  out  1  0 zero-extend, 1 sign-extend.
- `state`  out  4  current state, debug.
- `retired`  out  CNT_W  instructions completed since reset.

## Operation
- Supported: addu, subu, ori, lui, lw, sw, beq, j, jal, jr. Unknown opcode/funct: treated as nop.
- States: FETCH, DECODE, EXE_R, EXE_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_LW, BRANCH, JUMP, JUMP_R.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=ADD, pc_src=0.
  - mem_ready=1: ir_write=1, pc_write=1, go to DECODE.
  - mem_ready=0: no enables asserted, stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=ADD, ext_op=1. This precomputes the branch target into ALUOut.
- DECODE transitions:
  - R addu/subu: EXE_R.
  - jr: JUMP_R.
  - ori/lui: EXE_I.
  - lw/sw: MEM_ADDR.
  - beq: BRANCH.
  - j/jal: JUMP.
  - nop/unknown: FETCH.
- EXE_R: alu_src_a=1, alu_src_b=0, alu_op ADD/SUB from funct, then WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0, then FETCH.
- EXE_I: alu_src_b=2, ext_op=0, alu_op OR (ori) or LUI, then WB_I.
- WB_I: reg_write=1, reg_dst=0, then FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_op=1, ADD. Then MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req=1, iord=1. Stays until mem_ready=1, then WB_LW.
- WB_LW: reg_write=1, reg_dst=0, mem_to_reg=1, then FETCH.
- MEM_WR: mem_req=1, iord=1, mem_write=mem_ready. Stays until mem_ready=1, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1, pc_write=zero, then FETCH.
- JUMP: pc_src=2, pc_write=1. For jal only: reg_write=1, reg_dst=2, mem_to_reg=2. The GRF captures the old PC (already PC+4) on the same edge. Then FETCH.
- JUMP_R: pc_src=3, pc_write=1, then FETCH.
- retired increments by 1 on every transition into FETCH from a non-FETCH state. It wraps modulo 2^CNT_W.
- Outputs not listed for a state are 0.

## Timing
- State and retired are registers. All outputs are combinational from state, latched opcode/funct, zero and mem_ready.
- With mem_ready held at 1, cycles per instruction:
  - R-type and ori/lui: 4.
  - lw: 5.
  - sw: 4.
  - beq, j, jal, jr: 3.
  - nop: 2.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- reset low, at any time including mid-access: state=FETCH and retired=0 immediately. All write enables and mem_req are forced to 0 while reset is low.
- First fetch occurs on the first rising edge after reset deasserts.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.

## Structure
- Package `mips_defs`:
  - opcode constants: R=000000, ori=001101, lui=001111, lw=100011, sw=101011, beq=000100, j=000010, jal=000011.
  - funct constants: addu=100001, subu=100011, jr=001000.
  - state encodings and alu_op/pc_src/alu_src_b/reg_dst/mem_to_reg encodings.
- Sub-module `mc_decode`: combinational opcode/funct to instruction-class decode, instantiated once. The state machine and counter stay in `mc_ctrl`.

## Test plan
- Reset low mid-MEM_RD, then high: state=FETCH, retired=0, no reg_write or mem_write pulse. Fetch starts on the next edge.
- addu then lw, mem_ready=1: state sequence FETCH,DECODE,EXE_R,WB_R,FETCH,DECODE,MEM_ADDR,MEM_RD,WB_LW. retired=2 after 9 cycles.
- sw with mem_ready low for 3 cycles in MEM_WR: mem_write=0 for 3 cycles, mem_write=1 for exactly 1 cycle, then FETCH.
- beq with zero=1: pc_write=1, pc_src=1 in BRANCH. With zero=0: pc_write=0. Both paths return to FETCH, retired +1.
- jal: in JUMP, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2. jr: pc_src=3 in JUMP_R. Each takes 3 cycles.
- Unknown opcode 111111: FETCH, DECODE, FETCH, no write enables, retired +1. Preload retired near all-ones via force: counter wraps to 0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// FSM states, datapath mux selects and decoded instruction classes.
package mips_defs;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE_R    = 4'd2,
        S_EXE_I    = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_R     = 4'd7,
        S_WB_I     = 4'd8,
        S_WB_LW    = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JUMP_R   = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_OR  = 2'd2,
        ALU_LUI = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_ALU    = 2'd0,
        PC_ALUOUT = 2'd1,
        PC_JUMP   = 2'd2,
        PC_RS     = 2'd3
    } pc_src_t;

    typedef enum logic [1:0] {
        SRCB_RT      = 2'd0,
        SRCB_FOUR    = 2'd1,
        SRCB_IMM     = 2'd2,
        SRCB_IMM_SL2 = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MDR = 2'd1,
        M2R_PC  = 2'd2
    } mem_to_reg_t;

    typedef enum logic [3:0] {
        IC_NOP  = 4'd0,
        IC_ADDU = 4'd1,
        IC_SUBU = 4'd2,
        IC_JR   = 4'd3,
        IC_ORI  = 4'd4,
        IC_LUI  = 4'd5,
        IC_LW   = 4'd6,
        IC_SW   = 4'd7,
        IC_BEQ  = 4'd8,
        IC_J    = 4'd9,
        IC_JAL  = 4'd10
    } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational classification of the latched IR opcode/funct into one
// instruction class; anything unsupported collapses to IC_NOP.
module mc_decode
    import mips_defs::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output iclass_t    iclass
);

    // opcode first, funct only consulted for the R-type group
    always_comb begin
        iclass = IC_NOP;
        case (opcode)
            OP_R: begin
                case (funct)
                    FN_ADDU: iclass = IC_ADDU;
                    FN_SUBU: iclass = IC_SUBU;
                    FN_JR:   iclass = IC_JR;
                    default: iclass = IC_NOP;
                endcase
            end
            OP_ORI:  iclass = IC_ORI;
            OP_LUI:  iclass = IC_LUI;
            OP_LW:   iclass = IC_LW;
            OP_SW:   iclass = IC_SW;
            OP_BEQ:  iclass = IC_BEQ;
            OP_J:    iclass = IC_J;
            OP_JAL:  iclass = IC_JAL;
            default: iclass = IC_NOP;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back,
// drives datapath enables and selects, and counts retired instructions.
module mc_ctrl
    import mips_defs::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             ext_op,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_r;
    state_t           next_state_s;
    iclass_t          iclass_s;
    logic [CNT_W-1:0] retired_r;

    logic        mem_req_s;
    logic        pc_write_s;
    logic        ir_write_s;
    logic        mem_write_s;
    logic        reg_write_s;
    logic        iord_s;
    logic        alu_src_a_s;
    logic        ext_op_s;
    pc_src_t     pc_src_s;
    reg_dst_t    reg_dst_s;
    mem_to_reg_t mem_to_reg_s;
    alu_src_b_t  alu_src_b_s;
    alu_op_t     alu_op_s;

    mc_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .iclass (iclass_s)
    );

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // retire counter: every return to FETCH completes one instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_r <= {CNT_W{1'b0}};
        end else if ((next_state_s == S_FETCH) && (state_r != S_FETCH)) begin
            retired_r <= retired_r + CNT_ONE;
        end else begin
            retired_r <= retired_r;
        end
    end

    // next-state and per-state datapath controls
    always_comb begin
        next_state_s = state_r;
        mem_req_s    = 1'b0;
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        mem_write_s  = 1'b0;
        reg_write_s  = 1'b0;
        iord_s       = 1'b0;
        alu_src_a_s  = 1'b0;
        ext_op_s     = 1'b0;
        pc_src_s     = PC_ALU;
        reg_dst_s    = DST_RT;
        mem_to_reg_s = M2R_ALU;
        alu_src_b_s  = SRCB_RT;
        alu_op_s     = ALU_ADD;
        case (state_r)
            S_FETCH: begin
                mem_req_s   = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                if (mem_ready) begin
                    ir_write_s   = 1'b1;
                    pc_write_s   = 1'b1;
                    next_state_s = S_DECODE;
                end else begin
                    next_state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                // branch target is precomputed into ALUOut here
                alu_src_b_s = SRCB_IMM_SL2;
                ext_op_s    = 1'b1;
                case (iclass_s)
                    IC_ADDU, IC_SUBU: next_state_s = S_EXE_R;
                    IC_JR:            next_state_s = S_JUMP_R;
                    IC_ORI, IC_LUI:   next_state_s = S_EXE_I;
                    IC_LW, IC_SW:     next_state_s = S_MEM_ADDR;
                    IC_BEQ:           next_state_s = S_BRANCH;
                    IC_J, IC_JAL:     next_state_s = S_JUMP;
                    default:          next_state_s = S_FETCH;
                endcase
            end
            S_EXE_R: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = (iclass_s == IC_SUBU) ? ALU_SUB : ALU_ADD;
                next_state_s = S_WB_R;
            end
            S_WB_R: begin
                reg_write_s  = 1'b1;
                reg_dst_s    = DST_RD;
                next_state_s = S_FETCH;
            end
            S_EXE_I: begin
                alu_src_b_s  = SRCB_IMM;
                alu_op_s     = (iclass_s == IC_LUI) ? ALU_LUI : ALU_OR;
                next_state_s = S_WB_I;
            end
            S_WB_I: begin
                reg_write_s  = 1'b1;
                next_state_s = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a_s  = 1'b1;
                alu_src_b_s  = SRCB_IMM;
                ext_op_s     = 1'b1;
                next_state_s = (iclass_s == IC_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req_s    = 1'b1;
                iord_s       = 1'b1;
                next_state_s = mem_ready ? S_WB_LW : S_MEM_RD;
            end
            S_WB_LW: begin
                reg_write_s  = 1'b1;
                mem_to_reg_s = M2R_MDR;
                next_state_s = S_FETCH;
            end
            S_MEM_WR: begin
                mem_req_s    = 1'b1;
                iord_s       = 1'b1;
                mem_write_s  = mem_ready;
                next_state_s = mem_ready ? S_FETCH : S_MEM_WR;
            end
            S_BRANCH: begin
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALU_SUB;
                pc_src_s     = PC_ALUOUT;
                pc_write_s   = zero;
                next_state_s = S_FETCH;
            end
            S_JUMP: begin
                pc_src_s   = PC_JUMP;
                pc_write_s = 1'b1;
                // the GRF captures PC (already PC+4) on the same edge as the jump
                if (iclass_s == IC_JAL) begin
                    reg_write_s  = 1'b1;
                    reg_dst_s    = DST_RA;
                    mem_to_reg_s = M2R_PC;
                end else begin
                    reg_write_s  = 1'b0;
                end
                next_state_s = S_FETCH;
            end
            S_JUMP_R: begin
                pc_src_s     = PC_RS;
                pc_write_s   = 1'b1;
                next_state_s = S_FETCH;
            end
            default: begin
                next_state_s = S_FETCH;
            end
        endcase
    end

    // enables are held off for as long as reset is asserted
    assign mem_req    = mem_req_s   & reset;
    assign pc_write   = pc_write_s  & reset;
    assign ir_write   = ir_write_s  & reset;
    assign mem_write  = mem_write_s & reset;
    assign reg_write  = reg_write_s & reset;
    assign iord       = iord_s;
    assign alu_src_a  = alu_src_a_s;
    assign ext_op     = ext_op_s;
    assign pc_src     = pc_src_s;
    assign reg_dst    = reg_dst_s;
    assign mem_to_reg = mem_to_reg_s;
    assign alu_src_b  = alu_src_b_s;
    assign alu_op     = alu_op_s;
    assign state      = state_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: state sequences, stalls, branch/jump controls,
// reset mid-access and retire-counter wrap on a narrow-counter instance.
module tb_mc_ctrl;
    import mips_defs::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, pc_write, ir_write, iord, mem_write, reg_write;
    logic        alu_src_a, ext_op;
    logic [1:0]  pc_src, reg_dst, mem_to_reg, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        w_mem_req, w_pc_write, w_ir_write, w_iord, w_mem_write, w_reg_write;
    logic        w_alu_src_a, w_ext_op;
    logic [1:0]  w_pc_src, w_reg_dst, w_mem_to_reg, w_alu_src_b, w_alu_op;
    logic [3:0]  w_state;
    logic [2:0]  w_retired;

    int checks = 0;
    int failures = 0;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_op(ext_op), .state(state),
        .retired(retired)
    );

    mc_ctrl #(.CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(w_mem_req), .pc_write(w_pc_write), .pc_src(w_pc_src),
        .ir_write(w_ir_write), .iord(w_iord), .mem_write(w_mem_write), .reg_write(w_reg_write),
        .reg_dst(w_reg_dst), .mem_to_reg(w_mem_to_reg), .alu_src_a(w_alu_src_a),
        .alu_src_b(w_alu_src_b), .alu_op(w_alu_op), .ext_op(w_ext_op), .state(w_state),
        .retired(w_retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        zero = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (state !== S_FETCH || retired !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: state=%0d retired=%0d expected state=0 retired=0", state, retired);
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if ({mem_req, pc_write, ir_write, mem_write, reg_write} !== 5'b0) begin
            failures++;
            $display("FAIL reset_enables: got %b expected 00000", {mem_req, pc_write, ir_write, mem_write, reg_write});
        end
        step();
        reset = 1'b1;
        opcode = 6'b111111;
        #1;
        checks++;
        if (state !== S_FETCH || mem_req !== 1'b1 || ir_write !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_fetch: state=%0d mem_req=%b ir_write=%b expected 0 1 1", state, mem_req, ir_write);
        end
        step();
        step();
        opcode = OP_LW;
        step();
        step();
        mem_ready = 1'b0;
        step();
        step();
        checks++;
        if (state !== S_MEM_RD || retired !== 32'd1) begin
            failures++;
            $display("FAIL pre_reset_mem_rd: state=%0d retired=%0d expected 5 1", state, retired);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (state !== S_FETCH || retired !== 32'd0 || reg_write !== 1'b0 ||
            mem_write !== 1'b0 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_mem_rd: state=%0d retired=%0d rw=%b mw=%b mreq=%b expected 0 0 0 0 0",
                     state, retired, reg_write, mem_write, mem_req);
        end
        step();
        reset = 1'b1;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== S_FETCH) begin
            failures++;
            $display("FAIL reset_hold_fetch: state=%0d expected 0", state);
        end
        step();
        checks++;
        if (state !== S_DECODE) begin
            failures++;
            $display("FAIL first_fetch_edge: state=%0d expected 1", state);
        end
    endtask

    task automatic test_addu_lw();
        state_t seq [9] = '{S_FETCH, S_DECODE, S_EXE_R, S_WB_R,
                            S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_WB_LW};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            opcode = (i < 4) ? OP_R : OP_LW;
            funct  = FN_ADDU;
            #1;
            checks++;
            if (state !== seq[i]) begin
                failures++;
                $display("FAIL addu_lw_seq[%0d]: state=%0d expected %0d", i, state, seq[i]);
            end
            if (i == 2) begin
                checks++;
                if (alu_op !== 2'd0 || alu_src_a !== 1'b1 || alu_src_b !== 2'd0) begin
                    failures++;
                    $display("FAIL exe_r_addu: op=%0d a=%0d b=%0d expected 0 1 0", alu_op, alu_src_a, alu_src_b);
                end
            end
            if (i == 3) begin
                checks++;
                if (reg_write !== 1'b1 || reg_dst !== 2'd1 || mem_to_reg !== 2'd0) begin
                    failures++;
                    $display("FAIL wb_r: rw=%b dst=%0d m2r=%0d expected 1 1 0", reg_write, reg_dst, mem_to_reg);
                end
            end
            if (i == 7) begin
                checks++;
                if (mem_req !== 1'b1 || iord !== 1'b1 || mem_write !== 1'b0) begin
                    failures++;
                    $display("FAIL mem_rd: mreq=%b iord=%b mw=%b expected 1 1 0", mem_req, iord, mem_write);
                end
            end
            if (i == 8) begin
                checks++;
                if (reg_write !== 1'b1 || reg_dst !== 2'd0 || mem_to_reg !== 2'd1) begin
                    failures++;
                    $display("FAIL wb_lw: rw=%b dst=%0d m2r=%0d expected 1 0 1", reg_write, reg_dst, mem_to_reg);
                end
            end
            step();
        end
        checks++;
        if (state !== S_FETCH || retired !== 32'd2) begin
            failures++;
            $display("FAIL addu_lw_retired: state=%0d retired=%0d expected 0 2", state, retired);
        end
    endtask

    task automatic test_alu_variants();
        logic [5:0] ops [3] = '{OP_R, OP_ORI, OP_LUI};
        logic [1:0] exp_op [3] = '{2'd1, 2'd2, 2'd3};
        apply_reset();
        funct = FN_SUBU;
        for (int i = 0; i < 3; i++) begin
            opcode = ops[i];
            step();
            step();
            checks++;
            if (alu_op !== exp_op[i] || state !== ((i == 0) ? S_EXE_R : S_EXE_I)) begin
                failures++;
                $display("FAIL alu_variant[%0d]: op=%0d state=%0d expected %0d", i, alu_op, state, exp_op[i]);
            end
            if (i > 0) begin
                checks++;
                if (alu_src_b !== 2'd2 || ext_op !== 1'b0) begin
                    failures++;
                    $display("FAIL exe_i_srcb[%0d]: b=%0d ext=%0d expected 2 0", i, alu_src_b, ext_op);
                end
            end
            step();
            step();
        end
        checks++;
        if (state !== S_FETCH || retired !== 32'd3) begin
            failures++;
            $display("FAIL alu_variant_retired: state=%0d retired=%0d expected 0 3", state, retired);
        end
    endtask

    task automatic test_sw_stall();
        apply_reset();
        opcode = OP_SW;
        step();
        step();
        checks++;
        if (state !== S_MEM_ADDR || alu_src_a !== 1'b1 || alu_src_b !== 2'd2 || ext_op !== 1'b1) begin
            failures++;
            $display("FAIL mem_addr: state=%0d a=%0d b=%0d ext=%0d expected 4 1 2 1", state, alu_src_a, alu_src_b, ext_op);
        end
        mem_ready = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (state !== S_MEM_WR || mem_write !== 1'b0 || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL sw_stall[%0d]: state=%0d mw=%b mreq=%b expected 6 0 1", i, state, mem_write, mem_req);
            end
            step();
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (state !== S_MEM_WR || mem_write !== 1'b1 || iord !== 1'b1) begin
            failures++;
            $display("FAIL sw_write: state=%0d mw=%b iord=%b expected 6 1 1", state, mem_write, iord);
        end
        step();
        checks++;
        if (state !== S_FETCH || mem_write !== 1'b0 || retired !== 32'd1) begin
            failures++;
            $display("FAIL sw_done: state=%0d mw=%b retired=%0d expected 0 0 1", state, mem_write, retired);
        end
    endtask

    task automatic test_beq();
        apply_reset();
        opcode = OP_BEQ;
        for (int i = 0; i < 2; i++) begin
            zero = (i == 0) ? 1'b1 : 1'b0;
            step();
            step();
            checks++;
            if (state !== S_BRANCH || pc_write !== zero || pc_src !== 2'd1 || alu_op !== 2'd1) begin
                failures++;
                $display("FAIL beq[%0d]: state=%0d pcw=%b pcsrc=%0d op=%0d expected 10 %b 1 1",
                         i, state, pc_write, pc_src, alu_op, zero);
            end
            step();
            checks++;
            if (state !== S_FETCH || retired !== 32'(i + 1)) begin
                failures++;
                $display("FAIL beq_done[%0d]: state=%0d retired=%0d expected 0 %0d", i, state, retired, i + 1);
            end
        end
    endtask

    task automatic test_jump();
        apply_reset();
        opcode = OP_JAL;
        step();
        step();
        checks++;
        if (state !== S_JUMP || pc_write !== 1'b1 || reg_write !== 1'b1 || reg_dst !== 2'd2 ||
            mem_to_reg !== 2'd2 || pc_src !== 2'd2) begin
            failures++;
            $display("FAIL jal: state=%0d pcw=%b rw=%b dst=%0d m2r=%0d pcsrc=%0d expected 11 1 1 2 2 2",
                     state, pc_write, reg_write, reg_dst, mem_to_reg, pc_src);
        end
        step();
        opcode = OP_J;
        step();
        step();
        checks++;
        if (state !== S_JUMP || pc_write !== 1'b1 || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL j: state=%0d pcw=%b rw=%b expected 11 1 0", state, pc_write, reg_write);
        end
        step();
        opcode = OP_R;
        funct = FN_JR;
        step();
        step();
        checks++;
        if (state !== S_JUMP_R || pc_src !== 2'd3 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL jr: state=%0d pcsrc=%0d pcw=%b expected 12 3 1", state, pc_src, pc_write);
        end
        step();
        checks++;
        if (state !== S_FETCH || retired !== 32'd3) begin
            failures++;
            $display("FAIL jump_done: state=%0d retired=%0d expected 0 3", state, retired);
        end
    endtask

    task automatic test_unknown();
        apply_reset();
        opcode = 6'b111111;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (state !== S_FETCH || ir_write !== 1'b0 || pc_write !== 1'b0 || mem_req !== 1'b1) begin
                failures++;
                $display("FAIL fetch_stall[%0d]: state=%0d irw=%b pcw=%b mreq=%b expected 0 0 0 1",
                         i, state, ir_write, pc_write, mem_req);
            end
        end
        mem_ready = 1'b1;
        step();
        checks++;
        if (state !== S_DECODE ||
            {pc_write, ir_write, mem_write, reg_write, mem_req} !== 5'b0 ||
            alu_src_b !== 2'd3 || ext_op !== 1'b1) begin
            failures++;
            $display("FAIL unknown_decode: state=%0d en=%b b=%0d ext=%0d expected 1 00000 3 1", state,
                     {pc_write, ir_write, mem_write, reg_write, mem_req}, alu_src_b, ext_op);
        end
        step();
        checks++;
        if (state !== S_FETCH || retired !== 32'd1) begin
            failures++;
            $display("FAIL unknown_done: state=%0d retired=%0d expected 0 1", state, retired);
        end
        opcode = OP_R;
        funct = 6'b000000;
        step();
        step();
        checks++;
        if (state !== S_FETCH || retired !== 32'd2) begin
            failures++;
            $display("FAIL bad_funct_nop: state=%0d retired=%0d expected 0 2", state, retired);
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        opcode = 6'b111111;
        for (int i = 0; i < 7; i++) begin
            step();
            step();
        end
        checks++;
        if (w_retired !== 3'd7) begin
            failures++;
            $display("FAIL wrap_pre: retired=%0d expected 7", w_retired);
        end
        step();
        step();
        checks++;
        if (w_retired !== 3'd0 || retired !== 32'd8) begin
            failures++;
            $display("FAIL wrap: narrow=%0d wide=%0d expected 0 8", w_retired, retired);
        end
    endtask

    initial begin
        test_reset();
        test_addu_lw();
        test_alu_variants();
        test_sw_stall();
        test_beq();
        test_jump();
        test_unknown();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
